// File: rtl/bht_local_hist_if.sv
// Lookup, training and flush signals between the frontend/branch unit and the
// local-history branch history table.
interface bht_local_hist_if #(
    parameter int VLEN = 32
);
    logic            flush_i;
    logic            busy_o;
    logic            lookup_valid_i;
    logic [VLEN-1:0] lookup_pc_i;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic            upd_valid_i;
    logic [VLEN-1:0] upd_pc_i;
    logic            upd_taken_i;

    modport master (
        output flush_i, lookup_valid_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        input  busy_o, pred_valid_o, pred_taken_o
    );

    modport slave (
        input  flush_i, lookup_valid_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        output busy_o, pred_valid_o, pred_taken_o
    );
endinterface

// File: rtl/bht_local_hist.sv
// Per-PC local-history BHT: registered one-cycle prediction, saturating 2-bit
// counters selected by each entry's own history, and a one-entry-per-cycle flush sweep.
module bht_local_hist #(
    parameter int BHTEntries = 32,
    parameter int BHTHist    = 3,
    parameter int VLEN       = 32
) (
    input logic             clk_i,
    input logic             rst_ni,
    bht_local_hist_if.slave bus
);
    localparam int IdxW   = $clog2(BHTEntries);
    localparam int NumCtr = 1 << BHTHist;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]        state_q;
    logic [IdxW-1:0]   ptr_q;
    logic              pred_valid_q;
    logic              pred_taken_q;
    logic [BHTHist-1:0] hist_q [BHTEntries];
    logic [1:0]        ctr_q  [BHTEntries][NumCtr];

    logic [IdxW-1:0]    lookup_idx;
    logic [IdxW-1:0]    upd_idx;
    logic [BHTHist-1:0] lookup_hist;
    logic [BHTHist-1:0] upd_hist;
    logic [BHTHist:0]   shifted_hist;
    logic [BHTHist-1:0] new_hist;
    logic [1:0]         upd_ctr;
    logic [1:0]         new_ctr;
    logic               lookup_ok;
    logic               upd_ok;
    logic               unused_pc_bits;

    assign lookup_idx = bus.lookup_pc_i[IdxW:1];
    assign upd_idx    = bus.upd_pc_i[IdxW:1];
    assign unused_pc_bits = ^{bus.lookup_pc_i[VLEN-1:IdxW+1], bus.lookup_pc_i[0],
                              bus.upd_pc_i[VLEN-1:IdxW+1], bus.upd_pc_i[0]};

    assign lookup_ok = (state_q == IDLE) && !bus.flush_i && bus.lookup_valid_i;
    assign upd_ok    = (state_q == IDLE) && !bus.flush_i && bus.upd_valid_i;

    // New outcome enters at the LSB; the oldest bit falls off the top.
    always_comb begin
        lookup_hist  = hist_q[lookup_idx];
        upd_hist     = hist_q[upd_idx];
        upd_ctr      = ctr_q[upd_idx][upd_hist];
        shifted_hist = {upd_hist, bus.upd_taken_i};
        new_hist     = shifted_hist[BHTHist-1:0];
        new_ctr      = upd_ctr;
        if (bus.upd_taken_i) begin
            if (upd_ctr != 2'b11) new_ctr = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) new_ctr = upd_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            for (int e = 0; e < BHTEntries; e++) begin
                hist_q[e] <= '0;
                for (int c = 0; c < NumCtr; c++) ctr_q[e][c] <= 2'b01;
            end
        end else begin
            pred_valid_q <= lookup_ok;
            pred_taken_q <= lookup_ok && ctr_q[lookup_idx][lookup_hist][1];
            case (state_q)
                IDLE: begin
                    if (bus.flush_i) begin
                        state_q <= FLUSH;
                        ptr_q   <= '0;
                    end else if (upd_ok) begin
                        ctr_q[upd_idx][upd_hist] <= new_ctr;
                        hist_q[upd_idx]          <= new_hist;
                    end
                end
                default: begin
                    hist_q[ptr_q] <= '0;
                    for (int c = 0; c < NumCtr; c++) ctr_q[ptr_q][c] <= 2'b01;
                    if (bus.flush_i) begin
                        ptr_q <= '0;
                    end else if (ptr_q == '1) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + IdxW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.busy_o       = (state_q == FLUSH);
    assign bus.pred_valid_o = pred_valid_q;
    assign bus.pred_taken_o = pred_taken_q;
endmodule

// File: tb/tb_bht_local_hist.sv
// Directed bench for bht_local_hist: hand-computed predictions for training,
// aliasing, saturation, same-cycle collision, flush sweeps and mid-sweep reset.
module tb_bht_local_hist;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checkCount = 0;
    int   errorCount = 0;
    int   busyCycles;

    bht_local_hist_if #(.VLEN(32)) bus ();

    bht_local_hist #(
        .BHTEntries(32),
        .BHTHist   (3),
        .VLEN      (32)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are then sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic lv, input logic [31:0] lpc, input logic uv,
                                 input logic [31:0] upc, input logic ut, input logic fl);
        bus.lookup_valid_i = lv;
        bus.lookup_pc_i    = lpc;
        bus.upd_valid_i    = uv;
        bus.upd_pc_i       = upc;
        bus.upd_taken_i    = ut;
        bus.flush_i        = fl;
        @(posedge clk);
        #1;
        bus.lookup_valid_i = 1'b0;
        bus.upd_valid_i    = 1'b0;
        bus.upd_taken_i    = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic trainEntry(input logic [31:0] pc, input logic taken, input int times);
        for (int i = 0; i < times; i++) applyStimulus(1'b0, 32'h0, 1'b1, pc, taken, 1'b0);
    endtask

    task automatic lookupAndCheck(input string tag, input logic [31:0] pc, input logic expTaken);
        applyStimulus(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, "_valid"}, {31'b0, bus.pred_valid_o}, 32'd1);
        checkOutput({tag, "_taken"}, {31'b0, bus.pred_taken_o}, {31'b0, expTaken});
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_pc_i = '0;
        bus.upd_valid_i = 1'b0;
        bus.upd_pc_i = '0;
        bus.upd_taken_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, bus.busy_o}, 32'd0);
        checkOutput("rst_pred_valid", {31'b0, bus.pred_valid_o}, 32'd0);
        checkOutput("rst_pred_taken", {31'b0, bus.pred_taken_o}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] reset state lookup");
        lookupAndCheck("rst_lookup", 32'h8000_0000, 1'b0);
        checkOutput("rst_lookup_busy", {31'b0, bus.busy_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pred_valid_one_cycle", {31'b0, bus.pred_valid_o}, 32'd0);

        $display("[TB] history training");
        trainEntry(32'h100, 1'b1, 3);
        lookupAndCheck("train3", 32'h100, 1'b0);
        trainEntry(32'h100, 1'b1, 1);
        lookupAndCheck("train4", 32'h100, 1'b1);
        lookupAndCheck("alias_0x140", 32'h140, 1'b1);

        $display("[TB] saturation");
        trainEntry(32'h104, 1'b0, 6);
        lookupAndCheck("sat_low", 32'h104, 1'b0);
        trainEntry(32'h104, 1'b1, 1);
        trainEntry(32'h104, 1'b0, 3);
        lookupAndCheck("ctr000_is_01", 32'h104, 1'b0);
        trainEntry(32'h104, 1'b1, 1);
        trainEntry(32'h104, 1'b0, 3);
        lookupAndCheck("ctr000_is_10", 32'h104, 1'b1);

        $display("[TB] same-cycle collision");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        trainEntry(32'h200, 1'b1, 3);
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
        checkOutput("collide_valid", {31'b0, bus.pred_valid_o}, 32'd1);
        checkOutput("collide_taken", {31'b0, bus.pred_taken_o}, 32'd0);
        lookupAndCheck("after_collide", 32'h200, 1'b1);

        $display("[TB] flush sweep");
        lookupAndCheck("pre_flush", 32'h100, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        busyCycles = 0;
        while (bus.busy_o === 1'b1 && busyCycles < 40) begin
            busyCycles++;
            applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0);
            checkOutput("sweep_pred_valid", {31'b0, bus.pred_valid_o}, 32'd0);
        end
        checkOutput("busy_len", busyCycles, 32'd32);
        lookupAndCheck("post_flush", 32'h100, 1'b0);

        $display("[TB] flush restart");
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (19) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("busy_before_restart", {31'b0, bus.busy_o}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        busyCycles = 0;
        while (bus.busy_o === 1'b1 && busyCycles < 40) begin
            busyCycles++;
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        checkOutput("busy_restart_len", busyCycles, 32'd32);

        $display("[TB] reset mid-sweep");
        trainEntry(32'h000, 1'b1, 4);
        trainEntry(32'h014, 1'b1, 4);
        trainEntry(32'h03E, 1'b1, 4);
        lookupAndCheck("idx10_trained", 32'h014, 1'b1);
        lookupAndCheck("idx31_trained", 32'h03E, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (9) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("busy_at_cycle10", {31'b0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'b0, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lookupAndCheck("idx0_after_rst", 32'h000, 1'b0);
        lookupAndCheck("idx10_after_rst", 32'h014, 1'b0);
        lookupAndCheck("idx31_after_rst", 32'h03E, 1'b0);
        checkOutput("busy_after_rst", {31'b0, bus.busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/bht_local_hist.md
# bht_local_hist

Per-PC local-history branch history table for the CVA6 frontend, sized by the core configuration (`BHTEntries`, `BHTHist`). It sits between the fetch-address path, which issues lookups, and the branch unit's resolution port, which issues training updates. It returns a registered taken/not-taken prediction one cycle after each lookup. A sequential flush sweep clears the table one entry per cycle, so the storage maps onto single-port SRAM when `TechnoCut` builds need it.

## Interface
- `BHTEntries`, default 32: number of table entries; power of two, ≥2.
- `BHTHist`, default 3: local history length in bits; range 1..4.
- `VLEN`, default 32: virtual address width.
- Derived: `IdxW = $clog2(BHTEntries)`; each entry holds a `BHTHist`-bit history and `2**BHTHist` 2-bit counters.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `flush_i` in 1: start a full-table clear sweep.
- `busy_o` out 1: flush sweep in progress.
- `lookup_valid_i` in 1: lookup request.
- `lookup_pc_i` in VLEN: lookup address.
- `pred_valid_o` out 1: prediction valid; responds to the lookup of the previous cycle.
- `pred_taken_o` out 1: predicted direction.
- `upd_valid_i` in 1: resolved conditional branch.
- `upd_pc_i` in VLEN: resolved branch address.
- `upd_taken_i` in 1: resolved direction.

## Operation
- Index: `pc[IdxW:1]`. Addresses are 2-byte aligned (RVC) and bit 0 is ignored. PCs that differ only above bit `IdxW` alias to the same entry.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Prediction for entry e: `ctr[e][hist[e]][1]`.
- Update to entry e (state IDLE only):
  - Counter selected by the old `hist[e]` increments if taken and decrements if not taken, saturating at 11 and 00.
  - `hist[e]` becomes `{hist[e][BHTHist-2:0], upd_taken_i}`, with the new outcome entering at the LSB.
  - For `BHTHist=1`, `hist[e]` becomes `upd_taken_i`.
- Clear value of an entry: `hist=0`, all counters 01.
- FSM states:
  - IDLE → FLUSH when `flush_i=1`; `ptr` is set to 0 on the same edge.
  - FLUSH: each edge clears entry `ptr` and increments `ptr`. The edge that clears entry `BHTEntries-1` returns to IDLE.
  - `flush_i` asserted while in FLUSH: `ptr` goes back to 0 and the sweep restarts; the entry being cleared on that edge is still cleared.
- Updates are dropped when `flush_i=1` or when in FLUSH.
- Lookups issued when `flush_i=1` or when in FLUSH produce `pred_valid_o=0` on the next cycle.
- Lookup and update in the same cycle, same index: the prediction reflects the table contents *before* that update (read-before-write, no bypass).
- Reset (asynchronous, at any time, including mid-sweep):
  - All entries take the clear value.
  - FSM goes to IDLE and `ptr` to 0.
  - `busy_o=0`, `pred_valid_o=0`, `pred_taken_o=0`.

## Timing
- Lookup latency is 1 cycle. `pred_valid_o` and `pred_taken_o` are registered and each holds for one cycle per lookup.
- Throughput: one lookup and one update per cycle.
- `busy_o` is registered. It is high for exactly `BHTEntries` cycles, starting the cycle after `flush_i` is sampled; each restart extends it.
- An update sampled at edge k is visible to a lookup sampled at edge k+1 or later.
- No combinational path from any input to any output.

## Test plan
- **Reset state:** release reset, then lookup `0x8000_0000` → next cycle `pred_valid_o=1`, `pred_taken_o=0`; `busy_o=0` throughout.
- **History training** (defaults): 3 taken updates at `0x100`, then lookup `0x100` → NT (hist 111, `ctr[111]=01`). A 4th taken update, then lookup → T (`ctr[111]=10`).
- **Aliasing and saturation:**
  - After the 4 taken updates above, lookup `0x140` (same index 0) → T.
  - 6 not-taken updates at `0x104`, then lookup `0x104` → NT with hist 000 and `ctr[000]=00`.
  - One taken update at `0x104` → `ctr[000]` goes to 01 and hist to 001.
- **Same-cycle collision:** 3 taken updates at `0x200`, then lookup `0x200` together with a 4th taken update `0x200` → NT. Lookup on the following cycle → T.
- **Flush:**
  - Train `0x100` to T, then pulse `flush_i` → `busy_o` high for exactly 32 cycles.
  - Lookups during the sweep return `pred_valid_o=0`.
  - Updates during the sweep have no effect.
  - Lookup `0x100` after the sweep → NT.
  - A second `flush_i` at sweep cycle 20 → `busy_o` high for 32 further cycles.
- **Reset mid-sweep:** drive `rst_ni` low at sweep cycle 10 → `busy_o` goes to 0 asynchronously. After release, lookups at indices 0, 10 and 31 → NT with `pred_valid_o=1`.
